// File: rtl/add32_pkg.sv
// Shared types and constants for the 32-bit datapath adder.
// Flag evaluation lives here so every consumer agrees on its definition.
package add_pkg;

    localparam int ADD_W    = 32;
    localparam int ADD_LANE = 8;

    typedef logic [ADD_W-1:0] word_t;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } add_flags_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add32_if.sv
// Operand/result bundle for add32; master drives operands, slave is the adder.
interface add32_if;
    import add_pkg::*;

    word_t DataIn1;
    word_t DataIn2;
    word_t DataOut;
    logic  CarryOut;
    word_t DataOutQ;
    logic  CarryQ;
    logic  OvfQ;
    logic  ZeroQ;

    modport master (
        output DataIn1, DataIn2,
        input  DataOut, CarryOut, DataOutQ, CarryQ, OvfQ, ZeroQ
    );

    modport slave (
        input  DataIn1, DataIn2,
        output DataOut, CarryOut, DataOutQ, CarryQ, OvfQ, ZeroQ
    );

endinterface

// File: rtl/add32_cla_lane.sv
// One carry-lookahead lane: every internal carry is a flat sum of
// generate/propagate products, so no carry ripples inside the lane.
module cla_lane #(
    parameter int LANE = 8
) (
    input  logic [LANE-1:0] i_a,
    input  logic [LANE-1:0] i_b,
    input  logic            i_cin,
    output logic [LANE-1:0] o_sum,
    output logic            o_cout
);

    logic [LANE-1:0] w_g;
    logic [LANE-1:0] w_p;
    logic [LANE:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit.
    always_comb begin
        logic w_term;
        logic w_prod;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < LANE; i++) begin
            w_term = w_g[i];
            w_prod = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prod & w_g[j]);
                w_prod = w_prod & w_p[j];
            end
            w_c[i+1] = w_term | (w_prod & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[LANE-1:0];
    assign o_cout = w_c[LANE];

endmodule

// File: rtl/add32.sv
// Two-operand adder for PC+4 / branch-target: combinational sum and carry,
// plus a one-cycle registered copy of the sum with carry/overflow/zero flags.
module add32
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_W,
    parameter int LANE  = ADD_LANE
) (
    input  logic    clk,
    input  logic    rst,
    add32_if.slave  bus
);

    localparam int NLANES = WIDTH / LANE;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [NLANES:0]  w_lane_c;
    add_flags_t       w_flags;

    logic [WIDTH-1:0] r_sum;
    add_flags_t       r_flags;

    assign w_a         = bus.DataIn1;
    assign w_b         = bus.DataIn2;
    assign w_lane_c[0] = 1'b0;

    // Lanes are lookahead internally and ripple-chained lane to lane.
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        cla_lane #(.LANE(LANE)) u_lane (
            .i_a   (w_a[l*LANE +: LANE]),
            .i_b   (w_b[l*LANE +: LANE]),
            .i_cin (w_lane_c[l]),
            .o_sum (w_sum[l*LANE +: LANE]),
            .o_cout(w_lane_c[l+1])
        );
    end

    assign w_flags.carry = w_lane_c[NLANES];
    assign w_flags.ovf   = calc_ovf(w_a[WIDTH-1], w_b[WIDTH-1], w_sum[WIDTH-1]);
    assign w_flags.zero  = (w_sum == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_flags <= '0;
        end else begin
            r_sum   <= w_sum;
            r_flags <= w_flags;
        end
    end

    assign bus.DataOut  = w_sum;
    assign bus.CarryOut = w_flags.carry;
    assign bus.DataOutQ = r_sum;
    assign bus.CarryQ   = r_flags.carry;
    assign bus.OvfQ     = r_flags.ovf;
    assign bus.ZeroQ    = r_flags.zero;

endmodule

// File: tb/tb_add32.sv
// Directed and random checks of add32 combinational and registered outputs.
module tb_add32;
    import add_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    add32_if bus ();

    add32 dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive between edges, check comb at once, check registered after the next edge.
    task automatic vec(input string tag, input word_t a, input word_t b,
                       input word_t e_sum, input logic e_c, input logic e_ovf, input logic e_zero);
        @(negedge clk);
        bus.DataIn1 = a;
        bus.DataIn2 = b;
        #1;
        check({tag, ".DataOut"},  {1'b0, bus.DataOut},  {1'b0, e_sum});
        check({tag, ".CarryOut"}, {32'd0, bus.CarryOut}, {32'd0, e_c});
        @(posedge clk);
        #1;
        check({tag, ".DataOutQ"}, {1'b0, bus.DataOutQ}, {1'b0, e_sum});
        check({tag, ".CarryQ"},   {32'd0, bus.CarryQ},  {32'd0, e_c});
        check({tag, ".OvfQ"},     {32'd0, bus.OvfQ},    {32'd0, e_ovf});
        check({tag, ".ZeroQ"},    {32'd0, bus.ZeroQ},   {32'd0, e_zero});
    endtask

    initial begin
        word_t       ra;
        word_t       rb;
        logic [32:0] gold;
        logic        govf;
        logic        pq_valid;
        logic [32:0] pq_gold;
        logic        pq_ovf;

        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.DataIn1 = '0;
        bus.DataIn2 = '0;
        #2;
        check("reset.DataOutQ", {1'b0, bus.DataOutQ}, 33'd0);
        check("reset.ZeroQ",    {32'd0, bus.ZeroQ},   33'd0);
        check("reset.OvfQ",     {32'd0, bus.OvfQ},    33'd0);
        check("reset.CarryQ",   {32'd0, bus.CarryQ},  33'd0);
        #98;
        check("zero.DataOut",  {1'b0, bus.DataOut},   33'd0);
        check("zero.CarryOut", {32'd0, bus.CarryOut}, 33'd0);
        @(negedge clk);
        rst = 1'b0;

        vec("zero",   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        vec("four2",  32'h0000_0004, 32'h0000_0002, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        vec("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        vec("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vec("negovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        vec("lanecy", 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        vec("neg",    32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0);
        vec("alt",    32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        pq_valid = 1'b0;
        pq_gold  = '0;
        pq_ovf   = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            ra          = $random;
            rb          = $random;
            bus.DataIn1 = ra;
            bus.DataIn2 = rb;
            gold        = {1'b0, ra} + {1'b0, rb};
            govf        = ($signed(ra) < 0) == ($signed(rb) < 0) &&
                          (gold[31] != ra[31]);
            if (pq_valid) begin
                check("rand.DataOutQ", {1'b0, bus.DataOutQ}, {1'b0, pq_gold[31:0]});
                check("rand.CarryQ",   {32'd0, bus.CarryQ},  {32'd0, pq_gold[32]});
                check("rand.OvfQ",     {32'd0, bus.OvfQ},    {32'd0, pq_ovf});
                check("rand.ZeroQ",    {32'd0, bus.ZeroQ},   {32'd0, (pq_gold[31:0] == 32'd0)});
            end
            #1;
            check("rand.sum", {bus.CarryOut, bus.DataOut}, gold);
            pq_valid = 1'b1;
            pq_gold  = gold;
            pq_ovf   = govf;
        end

        vec("pre_rst", 32'h0000_0004, 32'h0000_0002, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.DataOutQ", {1'b0, bus.DataOutQ}, 33'd0);
        check("midrst.ZeroQ",    {32'd0, bus.ZeroQ},   33'd0);
        check("midrst.DataOut",  {1'b0, bus.DataOut},  33'd6);
        @(posedge clk);
        #1;
        check("midrst.hold", {1'b0, bus.DataOutQ}, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst.DataOutQ", {1'b0, bus.DataOutQ}, 33'd6);
        check("postrst.ZeroQ",    {32'd0, bus.ZeroQ},   33'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
